coin_change_dispenser: RTL and testbench



---
 rtl/coin_change_dispenser.sv | 132 +++++++++++++
 tb/tb_coin_change_dispenser.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_change_dispenser.sv
// -----------------------------------------------------------------------------
// coin_change_dispenser
//
// Change-return engine for the vending machine. It accepts a return amount
// from the balance logic and presents one coin at a time to the hopper. Coins
// are chosen greedily, largest first. The engine reports completion, the total
// value dispensed and any remainder that no coin can represent.
//
// Ports:
//   clk               clock; all state updates on the rising edge
//   reset             synchronous, active-high reset
//   i_start           request a return; sampled only in IDLE
//   i_amount          amount to return; latched when i_start is accepted
//   i_hopper_ready    hopper accepts the presented coin this cycle
//   o_return_coin     one-hot coin presented ([0]=COIN0 .. [2]=COIN2); 0 = none
//   o_busy            high in DISPENSE and DONE
//   o_done            one-cycle pulse at the end of a return
//   o_dispensed_total value of coins accepted since the last start
//   o_remainder       unreturned amount (< COIN0_VALUE); valid from o_done on
// -----------------------------------------------------------------------------
module coin_change_dispenser #(
  parameter int unsigned TOTAL_BITS  = 31,
  parameter int unsigned COIN0_VALUE = 100,
  parameter int unsigned COIN1_VALUE = 500,
  parameter int unsigned COIN2_VALUE = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [TOTAL_BITS-1:0] i_amount,
  input  logic                  i_hopper_ready,
  output logic [2:0]            o_return_coin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [TOTAL_BITS-1:0] o_dispensed_total,
  output logic [TOTAL_BITS-1:0] o_remainder
);

  localparam logic [TOTAL_BITS-1:0] COIN0 = TOTAL_BITS'(COIN0_VALUE);
  localparam logic [TOTAL_BITS-1:0] COIN1 = TOTAL_BITS'(COIN1_VALUE);
  localparam logic [TOTAL_BITS-1:0] COIN2 = TOTAL_BITS'(COIN2_VALUE);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPENSE = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  state_t                  state;
  logic [TOTAL_BITS-1:0]   remaining;
  logic [2:0]              coin_sel;
  logic [TOTAL_BITS-1:0]   coin_value;
  logic [TOTAL_BITS-1:0]   next_remaining;

  // Greedy coin choice. Only meaningful in DISPENSE, where remaining is
  // always >= COIN0, so exactly one bit is set there. Because it depends only
  // on registered state, the coin stays stable while the hopper stalls.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    coin_sel   = 3'b000;
    coin_value = '0;
    if (state == S_DISPENSE) begin
      if (remaining >= COIN2) begin
        coin_sel   = 3'b100;
        coin_value = COIN2;
      end else if (remaining >= COIN1) begin
        coin_sel   = 3'b010;
        coin_value = COIN1;
      end else if (remaining >= COIN0) begin
        coin_sel   = 3'b001;
        coin_value = COIN0;
      end
    end
  end

  // Never underflows: coin_value <= remaining by selection.
  assign next_remaining = remaining - coin_value;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      remaining         <= '0;
      o_dispensed_total <= '0;
      o_remainder       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            remaining         <= i_amount;
            o_dispensed_total <= '0;
            if (i_amount < COIN0) begin
              // Nothing dispensable: the whole amount is the remainder.
              o_remainder <= i_amount;
              state       <= S_DONE;
            end else begin
              o_remainder <= '0;
              state       <= S_DISPENSE;
            end
          end
        end

        S_DISPENSE: begin
          if (i_hopper_ready && (coin_sel != 3'b000)) begin
            remaining         <= next_remaining;
            o_dispensed_total <= o_dispensed_total + coin_value;
            if (next_remaining < COIN0) begin
              // Capture the remainder on entry to DONE so it is valid with o_done.
              o_remainder <= next_remaining;
              state       <= S_DONE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_return_coin = coin_sel;
  assign o_busy        = (state != S_IDLE);
  assign o_done        = (state == S_DONE);

endmodule

// File: tb/tb_coin_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_coin_change_dispenser
//
// Directed self-checking bench for coin_change_dispenser. Inputs change and
// outputs are sampled 1 ns after each rising edge. "Cycle k" is the cycle
// following the k-th rising edge after i_start was presented.
// -----------------------------------------------------------------------------
module tb_coin_change_dispenser;

  localparam int TB = 31;

  logic          clk;
  logic          reset;
  logic          i_start;
  logic [TB-1:0] i_amount;
  logic          i_hopper_ready;
  logic [2:0]    o_return_coin;
  logic          o_busy;
  logic          o_done;
  logic [TB-1:0] o_dispensed_total;
  logic [TB-1:0] o_remainder;

  int checks = 0;
  int errors = 0;

  coin_change_dispenser #(
    .TOTAL_BITS (TB),
    .COIN0_VALUE(100),
    .COIN1_VALUE(500),
    .COIN2_VALUE(1000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_start          (i_start),
    .i_amount         (i_amount),
    .i_hopper_ready   (i_hopper_ready),
    .o_return_coin    (o_return_coin),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_dispensed_total(o_dispensed_total),
    .o_remainder      (o_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one cycle; on return we are in cycle 1.
  task automatic start_return(input logic [TB-1:0] amt);
    i_start  = 1'b1;
    i_amount = amt;
    tick();
    i_start  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_return_coin, o_busy, o_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: coin=%b busy=%b done=%b, expected all 0", o_return_coin, o_busy, o_done);
    end
    checks++;
    if (o_dispensed_total !== '0 || o_remainder !== '0) begin
      errors++;
      $display("FAIL reset_totals: total=%0d rem=%0d, expected 0/0", o_dispensed_total, o_remainder);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_1700();
    logic [2:0]    exp_coin [4];
    logic [TB-1:0] exp_tot  [4];
    exp_coin = '{3'b100, 3'b010, 3'b001, 3'b001};
    exp_tot  = '{31'd0, 31'd1000, 31'd1500, 31'd1600};
    i_hopper_ready = 1'b1;
    start_return(31'd1700);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (o_return_coin !== exp_coin[c] || o_busy !== 1'b1 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL g1700_coin cyc%0d: coin=%b busy=%b done=%b, expected coin=%b busy=1 done=0",
                 c + 1, o_return_coin, o_busy, o_done, exp_coin[c]);
      end
      checks++;
      if (o_dispensed_total !== exp_tot[c]) begin
        errors++;
        $display("FAIL g1700_total cyc%0d: got %0d expected %0d", c + 1, o_dispensed_total, exp_tot[c]);
      end
      tick();
    end
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b1 || o_return_coin !== 3'b000 ||
        o_dispensed_total !== 31'd1700 || o_remainder !== 31'd0) begin
      errors++;
      $display("FAIL g1700_done: done=%b busy=%b coin=%b total=%0d rem=%0d, expected 1 1 000 1700 0",
               o_done, o_busy, o_return_coin, o_dispensed_total, o_remainder);
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_dispensed_total !== 31'd1700 || o_remainder !== 31'd0) begin
      errors++;
      $display("FAIL g1700_idle_hold: done=%b busy=%b total=%0d rem=%0d, expected 0 0 1700 0",
               o_done, o_busy, o_dispensed_total, o_remainder);
    end
  endtask

  task automatic test_250();
    i_hopper_ready = 1'b1;
    start_return(31'd250);
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (o_return_coin !== 3'b001 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL g250_coin cyc%0d: coin=%b done=%b, expected 001 0", c, o_return_coin, o_done);
      end
      tick();
    end
    checks++;
    if (o_done !== 1'b1 || o_dispensed_total !== 31'd200 || o_remainder !== 31'd50) begin
      errors++;
      $display("FAIL g250_done: done=%b total=%0d rem=%0d, expected 1 200 50",
               o_done, o_dispensed_total, o_remainder);
    end
    tick();
  endtask

  task automatic test_small_amounts();
    logic [TB-1:0] amts [2];
    amts = '{31'd0, 31'd99};
    i_hopper_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_return(amts[k]);
      checks++;
      if (o_return_coin !== 3'b000 || o_done !== 1'b1 || o_busy !== 1'b1 ||
          o_dispensed_total !== 31'd0 || o_remainder !== amts[k]) begin
        errors++;
        $display("FAIL small_%0d: coin=%b done=%b busy=%b total=%0d rem=%0d, expected 000 1 1 0 %0d",
                 amts[k], o_return_coin, o_done, o_busy, o_dispensed_total, o_remainder, amts[k]);
      end
      tick();
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL small_%0d_idle: busy=%b done=%b, expected 0 0", amts[k], o_busy, o_done);
      end
    end
  endtask

  task automatic test_stall();
    i_hopper_ready = 1'b0;
    start_return(31'd1000);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (o_return_coin !== 3'b100 || o_dispensed_total !== 31'd0 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: coin=%b total=%0d done=%b, expected 100 0 0",
                 c, o_return_coin, o_dispensed_total, o_done);
      end
      tick();
    end
    i_hopper_ready = 1'b1;
    checks++;
    if (o_return_coin !== 3'b100) begin
      errors++;
      $display("FAIL stall_cyc4: coin=%b expected 100", o_return_coin);
    end
    tick();
    checks++;
    if (o_done !== 1'b1 || o_dispensed_total !== 31'd1000 || o_remainder !== 31'd0) begin
      errors++;
      $display("FAIL stall_done: done=%b total=%0d rem=%0d, expected 1 1000 0",
               o_done, o_dispensed_total, o_remainder);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    i_hopper_ready = 1'b1;
    start_return(31'd1700);
    tick();                       // cycle 2: try to restart
    i_start  = 1'b1;
    i_amount = 31'd500;
    tick();                       // cycle 3
    i_start  = 1'b0;
    i_amount = 31'd0;
    checks++;
    if (o_return_coin !== 3'b001 || o_dispensed_total !== 31'd1500) begin
      errors++;
      $display("FAIL b2b_ignore: coin=%b total=%0d, expected 001 1500", o_return_coin, o_dispensed_total);
    end
    tick();                       // cycle 4
    tick();                       // cycle 5
    checks++;
    if (o_done !== 1'b1 || o_dispensed_total !== 31'd1700 || o_remainder !== 31'd0) begin
      errors++;
      $display("FAIL b2b_done: done=%b total=%0d rem=%0d, expected 1 1700 0",
               o_done, o_dispensed_total, o_remainder);
    end
    tick();                       // idle
    start_return(31'd500);
    checks++;
    if (o_return_coin !== 3'b010 || o_dispensed_total !== 31'd0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: coin=%b total=%0d busy=%b, expected 010 0 1",
               o_return_coin, o_dispensed_total, o_busy);
    end
    tick();
    checks++;
    if (o_done !== 1'b1 || o_dispensed_total !== 31'd500 || o_remainder !== 31'd0) begin
      errors++;
      $display("FAIL b2b_restart_done: done=%b total=%0d rem=%0d, expected 1 500 0",
               o_done, o_dispensed_total, o_remainder);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    i_hopper_ready = 1'b1;
    start_return(31'd1700);
    tick();                       // cycle 2
    reset = 1'b1;
    tick();                       // cycle 3: reset took effect
    reset = 1'b0;
    checks++;
    if (o_return_coin !== 3'b000 || o_busy !== 1'b0 || o_done !== 1'b0 ||
        o_dispensed_total !== '0 || o_remainder !== '0) begin
      errors++;
      $display("FAIL rmid_clear: coin=%b busy=%b done=%b total=%0d rem=%0d, expected all 0",
               o_return_coin, o_busy, o_done, o_dispensed_total, o_remainder);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (o_done !== 1'b0 || o_return_coin !== 3'b000) begin
        errors++;
        $display("FAIL rmid_quiet %0d: done=%b coin=%b, expected 0 000", c, o_done, o_return_coin);
      end
    end
    start_return(31'd250);
    tick();
    tick();
    checks++;
    if (o_done !== 1'b1 || o_dispensed_total !== 31'd200 || o_remainder !== 31'd50) begin
      errors++;
      $display("FAIL rmid_after: done=%b total=%0d rem=%0d, expected 1 200 50",
               o_done, o_dispensed_total, o_remainder);
    end
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    i_start        = 1'b0;
    i_amount       = '0;
    i_hopper_ready = 1'b1;
    test_reset();
    test_1700();
    test_250();
    test_small_amounts();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
